// File: rtl/dsm_pkg.sv
// Shared types and constants for the delta-sigma DAC output stage.
package dsm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dsm_state_t;

    // Sign-magnitude filter sample layout
    localparam int SIGN_BIT = 31;
    localparam int MAG_W    = 31;

    // Dither LFSR: 16-bit Fibonacci, taps 16,14,13,11
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dsm_fmt.sv
// Sign-magnitude filter sample to saturated offset-binary DAC code.
// Magnitude bits above the selected field clamp the field to full scale.
module dsm_fmt
    import dsm_pkg::*;
#(
    parameter int DW        = 12,
    parameter int FIELD_LSB = 13
)
(
    input  logic [31:0]   sample,
    output logic [DW-1:0] code
);

    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] above;
    logic [DW-2:0]    field;
    logic [DW-2:0]    sat;

    // Extract the field, clamp on overflow, then offset around midscale
    always_comb begin
        mag   = sample[MAG_W-1:0];
        above = mag >> (FIELD_LSB + DW - 1);
        field = mag[FIELD_LSB+DW-2:FIELD_LSB];
        sat   = (|above) ? '1 : field;
        if (sample[SIGN_BIT]) begin
            code = MID - {1'b0, sat};
        end else begin
            code = MID + {1'b0, sat};
        end
    end

endmodule

// File: rtl/dsm_dac.sv
// First-order delta-sigma DAC stage fed by an IIR filter channel.
// Accepts one sample per frame into a holding register, swaps it into the
// modulator at each frame boundary and emits a 1-bit oversampled stream.
// Optional feature: define DSM_DITHER_EN to add LFSR carry-in dither.
module dsm_dac
    import dsm_pkg::*;
#(
    parameter int DW        = 12,
    parameter int FIELD_LSB = 13,
    parameter int OSR_LOG2  = 6
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [31:0]   sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    output logic          sample_tick,
    output logic          dac_out,
    output logic [DW-1:0] active_code,
    output logic          underrun,
    input  logic          underrun_clr
);

    localparam logic [DW-1:0]       MID     = {1'b1, {(DW-1){1'b0}}};
    localparam logic [OSR_LOG2-1:0] CNT_MAX = '1;

    dsm_state_t          state;
    dsm_state_t          state_next;
    logic [OSR_LOG2-1:0] cnt;
    logic [DW-1:0]       fmt_code;
    logic [DW-1:0]       hold;
    logic                hold_full;
    logic                hold_full_next;
    logic [DW-1:0]       acc;
    logic [DW:0]         sum;
    logic                xfer;
    logic                load;
    logic                cin;

    dsm_fmt #(
        .DW        (DW),
        .FIELD_LSB (FIELD_LSB)
    ) u_fmt (
        .sample (sample_in),
        .code   (fmt_code)
    );

    // A handshake seen while disabled is dropped: the holding register is
    // forced empty whenever en is low, even in the one cycle where the
    // registered ready has not yet fallen.
    assign xfer        = sample_valid && sample_ready && en;
    assign sample_tick = en && (cnt == CNT_MAX);
    assign load        = sample_tick && hold_full;

`ifdef DSM_DITHER_EN
    logic [15:0] lfsr;

    // Dither source, parked at the seed while the modulator is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (!en) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign cin = lfsr[0];
`else
    assign cin = 1'b0;
`endif

    assign sum = {1'b0, acc} + {1'b0, active_code} + {{DW{1'b0}}, cin};

    // Holding register occupancy: emptied by a boundary load, filled by a transfer
    always_comb begin
        hold_full_next = hold_full;
        if (!en) begin
            hold_full_next = 1'b0;
        end else begin
            if (load) begin
                hold_full_next = 1'b0;
            end
            if (xfer) begin
                hold_full_next = 1'b1;
            end
        end
    end

    // Next state: start running on the first loaded sample, stop on disable
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = RUN;
            RUN:     if (!en)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame counter and first-order accumulator, both cleared while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            dac_out <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            acc     <= '0;
            dac_out <= 1'b0;
        end else begin
            cnt     <= cnt + OSR_LOG2'(1);
            acc     <= sum[DW-1:0];
            dac_out <= sum[DW];
        end
    end

    // Sample path: capture into hold, swap into the modulator at the boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold         <= '0;
            hold_full    <= 1'b0;
            sample_ready <= 1'b1;
            active_code  <= MID;
        end else begin
            hold_full    <= hold_full_next;
            sample_ready <= en && !hold_full_next;
            if (!en) begin
                hold <= '0;
            end else if (xfer) begin
                hold <= fmt_code;
            end
            if (load) begin
                active_code <= hold;
            end
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (sample_tick && !hold_full && (state == RUN)) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsm_dac.sv
// Self-checking bench for dsm_dac (default parameters, no dither).
// Expected codes come from an arithmetic model of the sample format;
// expected bitstream densities come from the code value itself.
module tb_dsm_dac;

    localparam int DW        = 12;
    localparam int FIELD_LSB = 13;
    localparam int OSR_LOG2  = 6;
    localparam int FRAME     = 1 << OSR_LOG2;
    localparam int DENS_N    = 1 << DW;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [31:0]   sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic          sample_tick;
    logic          dac_out;
    logic [DW-1:0] active_code;
    logic          underrun;
    logic          underrun_clr;

    int tests_run;
    int tests_failed;

    dsm_dac #(
        .DW        (DW),
        .FIELD_LSB (FIELD_LSB),
        .OSR_LOG2  (OSR_LOG2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_tick  (sample_tick),
        .dac_out      (dac_out),
        .active_code  (active_code),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer field, clamp to full scale, offset around midscale
    function automatic int fmt_model(input logic [31:0] s);
        longint mag;
        longint field;
        mag   = longint'(s[30:0]);
        field = mag / (longint'(1) << FIELD_LSB);
        if (field > (1 << (DW - 1)) - 1) field = (1 << (DW - 1)) - 1;
        return s[31] ? (1 << (DW - 1)) - int'(field) : (1 << (DW - 1)) + int'(field);
    endfunction

    function automatic logic [31:0] rand_sample();
        logic [31:0] r;
        r = $urandom;
        if (r[0]) begin
            r = {r[31], 7'b0, r[23:0]};
        end
        return r;
    endfunction

    // Waits (from a falling edge) for a tick cycle; a missing tick counts as a failure
    task automatic wait_tick();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (sample_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL tick_timeout: got no sample_tick, required one within %0d clocks", 4 * FRAME);
        end
    endtask

    // Presents a sample until accepted; returns at the falling edge after the transfer
    task automatic send_sample(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        sample_in    = d;
        sample_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (sample_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL ready_timeout: sample_ready stayed %b, required 1", sample_ready);
        end
    endtask

    task automatic count_ones(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dac_out === 1'b1) c++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests_run += 5;
        if (dac_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dac_out: got %b, required 0", dac_out);
        end
        if (sample_tick !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_tick: got %b, required 0", sample_tick);
        end
        if (sample_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b, required 1", sample_ready);
        end
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_underrun: got %b, required 0", underrun);
        end
        if (active_code !== 12'h800) begin
            tests_failed++;
            $display("[TB] FAIL reset_code: got %h, required 800", active_code);
        end
    endtask

    task automatic test_midscale();
        int bad;
        rst_n = 1'b1;
        en    = 1'b1;
        bad   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dac_out !== 1'(i % 2)) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL midscale_pattern: got %0d wrong bits, required 0,1 alternation", bad);
        end
        repeat (FRAME + 4) @(negedge clk);
        tests_run += 2;
        if (active_code !== 12'h800) begin
            tests_failed++;
            $display("[TB] FAIL midscale_code: got %h, required 800", active_code);
        end
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_no_underrun: got %b, required 0", underrun);
        end
    endtask

    task automatic load_and_check(input logic [31:0] s, input int exp_code, input int exp_ones,
                                  input bit do_density, input string name);
        int c;
        send_sample(s);
        wait_tick();
        @(negedge clk);
        tests_run++;
        if (active_code !== DW'(exp_code)) begin
            tests_failed++;
            $display("[TB] FAIL %s_code: got %h, required %h", name, active_code, exp_code);
        end
        if (do_density) begin
            count_ones(DENS_N, c);
            tests_run++;
            if (c != exp_ones) begin
                tests_failed++;
                $display("[TB] FAIL %s_density: got %0d ones, required %0d", name, c, exp_ones);
            end
        end
    endtask

    task automatic test_format();
        load_and_check(32'h0010_0000, 'h880, 2176, 1'b1, "fmt_pos");
        load_and_check(32'h8010_0000, 'h780, 0, 1'b0, "fmt_neg");
        load_and_check(32'h8000_0000, 'h800, 0, 1'b0, "fmt_negzero");
    endtask

    task automatic test_saturation();
        load_and_check(32'h4000_0000, 'hFFF, 4095, 1'b1, "sat_pos");
        load_and_check(32'hC000_0000, 'h001, 0, 1'b0, "sat_neg");
    endtask

    task automatic test_random();
        logic [31:0] s;
        for (int i = 0; i < 6; i++) begin
            s = rand_sample();
            load_and_check(s, fmt_model(s), fmt_model(s), (i == 0), "rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        int          bad;
        a = rand_sample();
        b = rand_sample();
        send_sample(a);
        sample_in    = b;
        sample_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (sample_tick === 1'b1) break;
            if (sample_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        tests_run++;
        if (bad != 0 || sample_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ready_low: got %0d high cycles while hold full, required 0", bad);
        end
        @(negedge clk);
        tests_run += 2;
        if (active_code !== DW'(fmt_model(a))) begin
            tests_failed++;
            $display("[TB] FAIL b2b_code_a: got %h, required %h", active_code, fmt_model(a));
        end
        if (sample_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_refill: got %b, required 1", sample_ready);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        tests_run++;
        if (sample_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_accept_b: got ready %b, required 0", sample_ready);
        end
        wait_tick();
        @(negedge clk);
        tests_run++;
        if (active_code !== DW'(fmt_model(b))) begin
            tests_failed++;
            $display("[TB] FAIL b2b_code_b: got %h, required %h", active_code, fmt_model(b));
        end
    endtask

    task automatic pulse_clear();
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
    endtask

    task automatic test_underrun();
        logic [31:0] x;
        logic [31:0] y;
        x = 32'h0010_0000;
        y = 32'h8010_0000;
        wait_tick();
        @(negedge clk);
        pulse_clear();
        tests_run++;
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL underrun_clear: got %b, required 0", underrun);
        end
        wait_tick();
        @(negedge clk);
        tests_run++;
        if (underrun !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL underrun_set: got %b, required 1", underrun);
        end
        pulse_clear();
        tests_run++;
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL underrun_clear2: got %b, required 0", underrun);
        end
        send_sample(x);
        wait_tick();
        @(negedge clk);
        tests_run += 2;
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fed_no_underrun: got %b, required 0", underrun);
        end
        if (active_code !== DW'(fmt_model(x))) begin
            tests_failed++;
            $display("[TB] FAIL fed_code: got %h, required %h", active_code, fmt_model(x));
        end
        // Transfer landing in the tick cycle: no bypass into the modulator
        wait_tick();
        sample_in    = y;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        tests_run += 3;
        if (underrun !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL tick_xfer_underrun: got %b, required 1", underrun);
        end
        if (active_code !== DW'(fmt_model(x))) begin
            tests_failed++;
            $display("[TB] FAIL tick_xfer_nobypass: got %h, required %h", active_code, fmt_model(x));
        end
        if (sample_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL tick_xfer_held: got ready %b, required 0", sample_ready);
        end
        wait_tick();
        @(negedge clk);
        tests_run++;
        if (active_code !== DW'(fmt_model(y))) begin
            tests_failed++;
            $display("[TB] FAIL tick_xfer_late_load: got %h, required %h", active_code, fmt_model(y));
        end
        pulse_clear();
        wait_tick();
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        tests_run++;
        if (underrun !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL set_beats_clear: got %b, required 1", underrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_sample(32'h0020_0000);
        tests_run++;
        if (sample_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_hold_full: got ready %b, required 0", sample_ready);
        end
        rst_n = 1'b0;
        #1;
        tests_run += 4;
        if (dac_out !== 1'b0 || sample_tick !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got dac %b tick %b, required 0 0", dac_out, sample_tick);
        end
        if (sample_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_ready: got %b, required 1", sample_ready);
        end
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_underrun: got %b, required 0", underrun);
        end
        if (active_code !== 12'h800) begin
            tests_failed++;
            $display("[TB] FAIL midreset_code: got %h, required 800", active_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (sample_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL release_ready: got %b, required 1", sample_ready);
        end
        wait_tick();
        @(negedge clk);
        tests_run += 2;
        if (active_code !== 12'h800) begin
            tests_failed++;
            $display("[TB] FAIL no_pending_survives: got %h, required 800", active_code);
        end
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got underrun %b, required 0", underrun);
        end
    endtask

    task automatic test_disable();
        int ticks;
        int ones;
        int bad;
        en = 1'b0;
        @(negedge clk);
        ticks = 0;
        ones  = 0;
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            if (sample_tick === 1'b1) ticks++;
            if (dac_out === 1'b1) ones++;
            @(negedge clk);
        end
        tests_run += 3;
        if (ticks != 0) begin
            tests_failed++;
            $display("[TB] FAIL disable_tick: got %0d ticks, required 0", ticks);
        end
        if (ones != 0) begin
            tests_failed++;
            $display("[TB] FAIL disable_dac_out: got %0d ones, required 0", ones);
        end
        if (sample_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL disable_ready: got %b, required 0", sample_ready);
        end
        en  = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dac_out !== 1'(i % 2)) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL reenable_pattern: got %0d wrong bits, required 0,1 alternation", bad);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        en           = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        test_reset();
        test_midscale();
        test_format();
        test_saturation();
        test_random();
        test_back_to_back();
        test_underrun();
        test_reset_mid_frame();
        test_disable();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
